// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the load/store access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Saturating 16-bit increment used by the optional statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store access controller in front of a 32x32 data memory whose write
// port is enabled combinationally while read is low. Every output is a
// register, so mem_read can only drop for the single ACCESS cycle of a store.
// Optional statistics (load_count, store_count, busy): MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out
`ifdef MEM_ACCESS_CTRL_STATS_EN
    ,
    output logic [15:0]       load_count,
    output logic [15:0]       store_count,
    output logic              busy
`endif
);

    state_t state;

    // Request/response FSM together with the registered memory-side drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_in     <= '0;
            mem_read   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b1;
                    if (req_valid && req_ready) begin
                        mem_addr  <= req_addr;
                        mem_in    <= req_wdata;
                        // a store opens the write window for the ACCESS cycle only
                        mem_read  <= ~req_op;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // for a store mem_out already shows the freshly written word
                    resp_rdata <= mem_out;
                    mem_read   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_CTRL_STATS_EN
    // Per-op transaction counters; in ACCESS a low mem_read identifies a store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (state == ACCESS) begin
            if (mem_read == OP_STORE) load_count  <= sat_inc16(load_count);
            else                      store_count <= sat_inc16(store_count);
        end
    end

    assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural 32x32 memory, a
// directed vector table, a reset-in-RESP sequence and randomized traffic
// checked against a plain array reference of the memory contents.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_in;
    logic        mem_read;
    logic [31:0] mem_out;
`ifdef MEM_ACCESS_CTRL_STATS_EN
    logic [15:0] load_count, store_count;
    logic        busy;
`endif

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_read(mem_read), .mem_out(mem_out)
`ifdef MEM_ACCESS_CTRL_STATS_EN
        , .load_count(load_count), .store_count(store_count), .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural data memory: preloaded with memory[i] = i, writes whenever read is low
    logic [31:0] mem [32];
    assign mem_out = mem[mem_addr];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = i;
        forever begin
            @(mem_read or mem_addr or mem_in);
            if (!mem_read) mem[mem_addr] = mem_in;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_mem [32];
    int exp_loads = 0;
    int exp_stores = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic        op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    // One full transaction from the negedge before accept to the negedge after the handshake
    task automatic run_txn(input logic op, input logic [4:0] addr, input logic [31:0] wdata,
                           input int hold, input logic [31:0] exp, input string nm);
        int lows;
        int lat;
        int w;
        lows = 0;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, ".ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        // scramble request inputs: they must be ignored from here on
        req_valid = 1'b0; req_op = ~op; req_addr = addr + 5'd1; req_wdata = ~wdata;
        chk({nm, ".ready_access"}, {31'd0, req_ready}, 32'd0);
        chk({nm, ".valid_access"}, {31'd0, resp_valid}, 32'd0);
`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk({nm, ".busy_access"}, {31'd0, busy}, 32'd1);
`endif
        lat = 1;
        if (!mem_read) lows++;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!mem_read) lows++;
        end
        chk({nm, ".latency"}, lat, 32'd2);
        chk({nm, ".rdata"}, resp_rdata, exp);
        // hold off the consumer and offer a competing request meanwhile
        req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!mem_read) lows++;
            chk({nm, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({nm, ".hold_rdata"}, resp_rdata, exp);
            chk({nm, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
`ifdef MEM_ACCESS_CTRL_STATS_EN
            chk({nm, ".busy_resp"}, {31'd0, busy}, 32'd1);
`endif
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b0;
        if (!mem_read) lows++;
        chk({nm, ".valid_after"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, ".ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({nm, ".read_low_cycles"}, lows, op ? 32'd1 : 32'd0);
`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk({nm, ".busy_idle"}, {31'd0, busy}, 32'd0);
`endif
        if (op) exp_stores++; else exp_loads++;
    endtask

    vec_t vecs [7];

    initial begin
        logic        op;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] ex;
        for (int i = 0; i < 32; i++) ref_mem[i] = i;

        vecs[0] = '{1'b0, 5'd7,  32'h0,        0, 32'd7};
        vecs[1] = '{1'b1, 5'd3,  32'hDEADBEEF, 0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd3,  32'h0,        1, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd31, 32'h0,        5, 32'd31};
        vecs[4] = '{1'b1, 5'd31, 32'h0,        2, 32'h0};
        vecs[5] = '{1'b0, 5'd31, 32'h0,        0, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        3, 32'd0};

        // reset values while reset is held
        #12;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst.mem_in", mem_in, 32'd0);
        chk("rst.mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.mem_read", {31'd0, mem_read}, 32'd1);
            chk("idle.ready", {31'd0, req_ready}, 32'd1);
            chk("idle.valid", {31'd0, resp_valid}, 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].exp,
                    $sformatf("vec%0d", i));
            if (vecs[i].op) ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk("stats.loads", {16'd0, load_count}, exp_loads);
        chk("stats.stores", {16'd0, store_count}, exp_stores);
`endif

        // reset while a response is pending: dropped at once, never re-issued
        req_valid = 1'b1; req_op = 1'b0; req_addr = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp.pending", {31'd0, resp_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rsp.valid_async", {31'd0, resp_valid}, 32'd0);
        chk("rsp.mem_read_async", {31'd0, mem_read}, 32'd1);
        chk("rsp.ready_async", {31'd0, req_ready}, 32'd1);
        exp_loads = 0; exp_stores = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_ready = 1'b1;
            @(negedge clk);
            chk("rsp.no_dup", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;
`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk("rsp.loads_cleared", {16'd0, load_count}, 32'd0);
`endif
        run_txn(1'b0, 5'd5, 32'h0, 0, ref_mem[5], "after_rst");

        // randomized traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            op   = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, 31));
            wd   = $urandom;
            ex   = op ? wd : ref_mem[addr];
            run_txn(op, addr, wd, $urandom_range(0, 3), ex, $sformatf("rnd%0d", i));
            if (op) ref_mem[addr] = wd;
        end

        for (int i = 0; i < 32; i++) chk($sformatf("final.mem%0d", i), mem[i], ref_mem[i]);

`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk("stats.loads_end", {16'd0, load_count}, exp_loads);
        chk("stats.stores_end", {16'd0, store_count}, exp_stores);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
